cp0_reg_file: RTL and testbench

Architectural CP0 register file for the pipeline. It holds BadVAddr, Count, Compare, Status, Cause and EPC. It applies MTC0 writes from WB, exception/ERET updates from the MEM-stage exception unit, and the Count/Compare timer. Its raw register values feed the CP0 read-forwarding logic, which produces the ID/MEM-visible values.

---
 rtl/cp0_reg_file.sv | 152 +++++++++++++++
 tb/tb_cp0_reg_file.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : cp0_reg_file
// Description : Architectural CP0 registers (BadVAddr, Count, Compare, Status,
//               Cause, EPC) with MTC0 writes, exception/ERET updates and timer.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_reg_file #(
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp0_write_en,
    input  logic [4:0]  cp0_write_addr,
    input  logic [31:0] cp0_write_data,
    input  logic [4:0]  cp0_read_addr,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delayslot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic [5:0]  int_i,
    output logic [31:0] cp0_read_data_o,
    output logic [31:0] cp0_status_o,
    output logic [31:0] cp0_cause_o,
    output logic [31:0] cp0_epc_o,
    output logic        timer_int_o
);

    localparam logic [4:0]  c_ADDR_BADVADDR = 5'd8;
    localparam logic [4:0]  c_ADDR_COUNT    = 5'd9;
    localparam logic [4:0]  c_ADDR_COMPARE  = 5'd11;
    localparam logic [4:0]  c_ADDR_STATUS   = 5'd12;
    localparam logic [4:0]  c_ADDR_CAUSE    = 5'd13;
    localparam logic [4:0]  c_ADDR_EPC      = 5'd14;
    localparam logic [31:0] c_STATUS_MASK   = 32'h0000_FF03;
    localparam logic [31:0] c_BEV_MASK      = 32'h0040_0000;
    localparam int          c_DIV_W         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(COUNT_DIV - 1);

    logic [31:0]        r_badvaddr;
    logic [31:0]        r_count;
    logic [31:0]        r_compare;
    logic [31:0]        r_status;
    logic [31:0]        r_epc;
    logic               r_bd;
    logic               r_ti;
    logic [5:0]         r_ip_hw;
    logic [1:0]         r_ip_sw;
    logic [4:0]         r_exc_code;
    logic [c_DIV_W-1:0] r_div;

    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_div_tick;
    logic        w_exc_addr;
    logic [31:0] w_exc_epc;

    assign w_wr_count   = cp0_write_en && (cp0_write_addr == c_ADDR_COUNT);
    assign w_wr_compare = cp0_write_en && (cp0_write_addr == c_ADDR_COMPARE);
    assign w_wr_status  = cp0_write_en && (cp0_write_addr == c_ADDR_STATUS);
    assign w_wr_cause   = cp0_write_en && (cp0_write_addr == c_ADDR_CAUSE);
    assign w_wr_epc     = cp0_write_en && (cp0_write_addr == c_ADDR_EPC);
    assign w_div_tick   = (r_div == c_DIV_LAST);
    assign w_exc_addr   = (exc_code == 5'h04) || (exc_code == 5'h05);
    assign w_exc_epc    = exc_in_delayslot ? (exc_pc - 32'd4) : exc_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_status   <= STATUS_RESET & c_STATUS_MASK;
            r_epc      <= '0;
            r_bd       <= 1'b0;
            r_ti       <= 1'b0;
            r_ip_hw    <= '0;
            r_ip_sw    <= '0;
            r_exc_code <= '0;
            r_div      <= '0;
        end else begin
            if (w_wr_count) begin
                r_count <= cp0_write_data;
                r_div   <= '0;
            end else begin
                r_div <= w_div_tick ? '0 : r_div + 1'b1;
                if (w_div_tick) begin
                    r_count <= r_count + 32'd1;
                end
            end

            if (w_wr_compare) begin
                r_compare <= cp0_write_data;
                r_ti      <= 1'b0;
            end else if ((r_count == r_compare) && (r_compare != '0)) begin
                r_ti <= 1'b1;
            end

            r_ip_hw <= {int_i[5] | r_ti, int_i[4:0]};

            if (w_wr_status) begin
                r_status <= cp0_write_data & c_STATUS_MASK;
            end
            if (w_wr_cause) begin
                r_ip_sw <= cp0_write_data[9:8];
            end
            if (w_wr_epc) begin
                r_epc <= cp0_write_data;
            end

            // Later assignments override the MTC0 write only on the fields they touch.
            if (exc_valid) begin
                if (!r_status[1]) begin
                    r_epc <= w_exc_epc;
                    r_bd  <= exc_in_delayslot;
                end
                r_status[1] <= 1'b1;
                r_exc_code  <= exc_code;
                if (w_exc_addr) begin
                    r_badvaddr <= exc_badvaddr;
                end
            end else if (eret) begin
                r_status[1] <= 1'b0;
            end
        end
    end

    assign cp0_status_o = (r_status & c_STATUS_MASK) | (STATUS_RESET & c_BEV_MASK);
    assign cp0_cause_o  = {r_bd, r_ti, 14'b0, r_ip_hw, r_ip_sw, 1'b0, r_exc_code, 2'b0};
    assign cp0_epc_o    = r_epc;
    assign timer_int_o  = r_ti;

    always_comb begin
        cp0_read_data_o = '0;
        case (cp0_read_addr)
            c_ADDR_BADVADDR: cp0_read_data_o = r_badvaddr;
            c_ADDR_COUNT:    cp0_read_data_o = r_count;
            c_ADDR_COMPARE:  cp0_read_data_o = r_compare;
            c_ADDR_STATUS:   cp0_read_data_o = cp0_status_o;
            c_ADDR_CAUSE:    cp0_read_data_o = cp0_cause_o;
            c_ADDR_EPC:      cp0_read_data_o = r_epc;
            default:         cp0_read_data_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_reg_file
// Description : Self-checking bench for cp0_reg_file (vector table, directed
//               sequences and randomized traffic against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_reg_file;

    localparam int          COUNT_DIV    = 2;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cp0_write_en;
    logic [4:0]  cp0_write_addr;
    logic [31:0] cp0_write_data;
    logic [4:0]  cp0_read_addr;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delayslot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  int_i;
    logic [31:0] cp0_read_data_o;
    logic [31:0] cp0_status_o;
    logic [31:0] cp0_cause_o;
    logic [31:0] cp0_epc_o;
    logic        timer_int_o;

    int checks   = 0;
    int failures = 0;

    cp0_reg_file #(
        .COUNT_DIV   (COUNT_DIV),
        .STATUS_RESET(STATUS_RESET)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cp0_write_en    (cp0_write_en),
        .cp0_write_addr  (cp0_write_addr),
        .cp0_write_data  (cp0_write_data),
        .cp0_read_addr   (cp0_read_addr),
        .exc_valid       (exc_valid),
        .exc_code        (exc_code),
        .exc_pc          (exc_pc),
        .exc_in_delayslot(exc_in_delayslot),
        .exc_badvaddr    (exc_badvaddr),
        .eret            (eret),
        .int_i           (int_i),
        .cp0_read_data_o (cp0_read_data_o),
        .cp0_status_o    (cp0_status_o),
        .cp0_cause_o     (cp0_cause_o),
        .cp0_epc_o       (cp0_epc_o),
        .timer_int_o     (timer_int_o)
    );

    always #5 clk = ~clk;

    // Reference model: architectural view of each register as a full word.
    logic [31:0] m_badv, m_count, m_compare, m_status, m_cause, m_epc;
    logic        m_ti;
    int          m_div;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_update();
        logic [31:0] n_badv, n_count, n_compare, n_status, n_cause, n_epc;
        logic        n_ti;
        int          n_div;
        if (rst) begin
            m_badv = 0; m_count = 0; m_compare = 0; m_epc = 0; m_cause = 0;
            m_status = STATUS_RESET & 32'h0040_FF03;
            m_ti = 1'b0; m_div = 0;
            return;
        end
        n_badv = m_badv; n_count = m_count; n_compare = m_compare;
        n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_ti = m_ti;
        if (cp0_write_en && cp0_write_addr == 5'd9) begin
            n_count = cp0_write_data;
            n_div   = 0;
        end else begin
            n_div   = (m_div + 1) % COUNT_DIV;
            n_count = (m_div == COUNT_DIV - 1) ? m_count + 32'd1 : m_count;
        end
        if (cp0_write_en && cp0_write_addr == 5'd11) begin
            n_compare = cp0_write_data;
            n_ti      = 1'b0;
        end else if (m_count == m_compare && m_compare != 0) begin
            n_ti = 1'b1;
        end
        if (cp0_write_en && cp0_write_addr == 5'd12)
            n_status = (cp0_write_data & 32'h0000_FF03) | (STATUS_RESET & 32'h0040_0000);
        if (cp0_write_en && cp0_write_addr == 5'd13)
            n_cause[9:8] = cp0_write_data[9:8];
        if (cp0_write_en && cp0_write_addr == 5'd14)
            n_epc = cp0_write_data;
        n_cause[15:10] = {int_i[5] | m_ti, int_i[4:0]};
        n_cause[30]    = n_ti;
        if (exc_valid) begin
            if (!m_status[1]) begin
                n_epc       = exc_in_delayslot ? exc_pc - 32'd4 : exc_pc;
                n_cause[31] = exc_in_delayslot;
            end
            n_status[1]   = 1'b1;
            n_cause[6:2]  = exc_code;
            if (exc_code == 5'h04 || exc_code == 5'h05) n_badv = exc_badvaddr;
        end else if (eret) begin
            n_status[1] = 1'b0;
        end
        m_badv = n_badv; m_count = n_count; m_compare = n_compare; m_status = n_status;
        m_cause = n_cause; m_epc = n_epc; m_ti = n_ti; m_div = n_div;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("model_status", cp0_status_o, m_status);
        check("model_cause", cp0_cause_o, m_cause);
        check("model_epc", cp0_epc_o, m_epc);
        check("model_timer", {31'b0, timer_int_o}, {31'b0, m_ti});
        check("model_read", cp0_read_data_o, model_read(cp0_read_addr));
    endtask

    task automatic idle_inputs();
        cp0_write_en = 0; cp0_write_addr = 0; cp0_write_data = 0;
        exc_valid = 0; exc_code = 0; exc_pc = 0; exc_in_delayslot = 0;
        exc_badvaddr = 0; eret = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_write_en = 1; cp0_write_addr = a; cp0_write_data = d;
        step();
        cp0_write_en = 0;
    endtask

    task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc,
                             input logic ds, input logic [31:0] bad);
        exc_valid = 1; exc_code = code; exc_pc = pc; exc_in_delayslot = ds; exc_badvaddr = bad;
        step();
        exc_valid = 0;
    endtask

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];
    bit   seen;

    initial begin
        vecs[0] = '{5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03};
        vecs[1] = '{5'd8,  32'h0000_1234, 5'd8,  32'h0000_0000};
        vecs[2] = '{5'd14, 32'hDEAD_BEEF, 5'd14, 32'hDEAD_BEEF};
        vecs[3] = '{5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
        vecs[4] = '{5'd5,  32'h0000_0055, 5'd5,  32'h0000_0000};
        vecs[5] = '{5'd11, 32'h1234_5678, 5'd11, 32'h1234_5678};
        vecs[6] = '{5'd12, 32'h0000_0000, 5'd12, 32'h0040_0000};
        vecs[7] = '{5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};

        idle_inputs();
        int_i = 0; cp0_read_addr = 5'd12; rst = 1;
        m_div = 0;
        step();
        check("reset_status", cp0_status_o, 32'h0040_0000);
        check("reset_cause", cp0_cause_o, 32'h0);
        check("reset_epc", cp0_epc_o, 32'h0);
        check("reset_timer", {31'b0, timer_int_o}, 32'h0);
        rst = 0; cp0_read_addr = 5'd9;
        for (int i = 0; i < 10; i++) step();
        check("count_after_10", cp0_read_data_o, 32'd5);

        for (int i = 0; i < 8; i++) begin
            cp0_read_addr = vecs[i].raddr;
            mtc0(vecs[i].waddr, vecs[i].wdata);
            check($sformatf("vec%0d_read", i), cp0_read_data_o, vecs[i].exp);
        end

        // Timer: Count from 0, Compare 4, wait for TI.
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd4);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            seen = timer_int_o;
        end
        check("timer_rise", {31'b0, timer_int_o}, 32'd1);
        check("cause_ti", {31'b0, cp0_cause_o[30]}, 32'd1);
        step();
        check("cause_ip7", {31'b0, cp0_cause_o[15]}, 32'd1);
        mtc0(5'd11, 32'd100);
        check("timer_clear", {31'b0, timer_int_o}, 32'd0);
        mtc0(5'd11, 32'd0);

        // Exceptions and ERET.
        cp0_read_addr = 5'd8;
        raise_exc(5'h04, 32'hBFC0_0100, 1'b1, 32'h8000_0003);
        check("exc_epc", cp0_epc_o, 32'hBFC0_00FC);
        check("exc_cause", cp0_cause_o, 32'h8000_0010);
        check("exc_badvaddr", cp0_read_data_o, 32'h8000_0003);
        check("exc_status", cp0_status_o, 32'h0040_0002);
        raise_exc(5'h0C, 32'h0000_0200, 1'b0, 32'h0);
        check("exc2_epc", cp0_epc_o, 32'hBFC0_00FC);
        check("exc2_code", {27'b0, cp0_cause_o[6:2]}, 32'h0C);
        eret = 1; step(); eret = 0;
        check("eret_status", cp0_status_o, 32'h0040_0000);
        eret = 1;
        raise_exc(5'h0A, 32'h0000_0300, 1'b0, 32'h0);
        eret = 0;
        check("exc_eret_status", cp0_status_o, 32'h0040_0002);
        check("exc_eret_code", {27'b0, cp0_cause_o[6:2]}, 32'h0A);
        check("exc_eret_epc", cp0_epc_o, 32'h0000_0300);
        eret = 1; step(); eret = 0;
        cp0_write_en = 1; cp0_write_addr = 5'd12; cp0_write_data = 32'h0000_FF01;
        raise_exc(5'h00, 32'h0000_0400, 1'b0, 32'h0);
        cp0_write_en = 0;
        check("mtc0_exc_status", cp0_status_o, 32'h0040_FF03);

        int_i = 6'b000001; step(); int_i = 0;
        check("int0_ip2", {31'b0, cp0_cause_o[10]}, 32'd1);

        // Reset mid-operation with pending inputs.
        rst = 1; cp0_write_en = 1; cp0_write_addr = 5'd14; cp0_write_data = 32'h1111_1111;
        exc_valid = 1; exc_code = 5'h05;
        step();
        idle_inputs();
        check("midreset_status", cp0_status_o, 32'h0040_0000);
        check("midreset_epc", cp0_epc_o, 32'h0);
        check("midreset_cause", cp0_cause_o, 32'h0);
        rst = 0;

        for (int i = 0; i < 600; i++) begin
            logic [4:0] addrs[7];
            addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'($urandom)};
            rst              = ($urandom_range(0, 79) == 0);
            cp0_write_en     = ($urandom_range(0, 2) == 0);
            cp0_write_addr   = addrs[$urandom_range(0, 6)];
            cp0_write_data   = (cp0_write_addr == 5'd9 || cp0_write_addr == 5'd11)
                               ? 32'($urandom_range(0, 40)) : $urandom;
            cp0_read_addr    = addrs[$urandom_range(0, 6)];
            exc_valid        = ($urandom_range(0, 7) == 0);
            exc_code         = ($urandom_range(0, 1) == 0) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom);
            exc_pc           = $urandom;
            exc_in_delayslot = 1'($urandom);
            exc_badvaddr     = $urandom;
            eret             = ($urandom_range(0, 7) == 0);
            int_i            = 6'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
